// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a programmable N-bit pattern.
// Samples data_in_i on enabled edges and emits a one-cycle registered pulse when the
// last N sampled bits equal the current pattern. A saturating counter tallies matches.
//
// Parameters:
//   N            - pattern length in bits (2..32)
//   INIT_PATTERN - pattern loaded on reset; bit N-1 is the first bit received
//   OVERLAP      - 1: overlapping matches allowed; 0: history restarts after a match
//   COUNT_W      - width of the match counter (>= 1)
//
// Ports:
//   clk           - clock, rising edge
//   reset         - synchronous, active-high reset
//   en_i          - data_in_i is sampled only when high
//   data_in_i     - serial input bit
//   cfg_load_i    - load cfg_pattern_i and clear history (overrides en_i)
//   cfg_pattern_i - new pattern
//   data_out_o    - registered match pulse
//   match_count_o - saturating count of matches since reset
module seq_detect_param #(
  parameter int unsigned N            = 4,
  parameter logic [N-1:0] INIT_PATTERN = 4'b1011,
  parameter int unsigned OVERLAP      = 1,
  parameter int unsigned COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               data_in_i,
  input  logic               cfg_load_i,
  input  logic [N-1:0]       cfg_pattern_i,
  output logic               data_out_o,
  output logic [COUNT_W-1:0] match_count_o
);

  localparam int unsigned FillW = $clog2(N + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(N);

  logic [N-1:0]       hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [N-1:0]       pat_q, pat_d;
  logic               data_out_q, data_out_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [N-1:0]     next_hist;
  logic [FillW-1:0] next_fill;
  logic             match;

  always_comb begin
    // Candidate history/fill if this edge samples a bit; newest bit lands in bit 0.
    next_hist = {hist_q[N-2:0], data_in_i};
    next_fill = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
    match     = (next_fill == FillMax) && (next_hist == pat_q);
  end

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    data_out_d = 1'b0;
    count_d    = count_q;

    if (cfg_load_i) begin
      // The bit presented alongside a load is dropped.
      pat_d  = cfg_pattern_i;
      hist_d = '0;
      fill_d = '0;
    end else if (en_i) begin
      hist_d     = next_hist;
      data_out_d = match;
      if ((OVERLAP == 0) && match) begin
        fill_d = '0;
      end else begin
        fill_d = next_fill;
      end
      if (match && (count_q != {COUNT_W{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q     <= '0;
      fill_q     <= '0;
      pat_q      <= INIT_PATTERN;
      data_out_q <= 1'b0;
      count_q    <= '0;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
    end
  end

  assign data_out_o    = data_out_q;
  assign match_count_o = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances share one stimulus stream
// (overlap/default, non-overlap, and a 2-bit counter with pattern 1111).
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       data_in;
  logic       cfg_load;
  logic [3:0] cfg_pattern;

  logic       ov_out;
  logic [7:0] ov_cnt;
  logic       no_out;
  logic [7:0] no_cnt;
  logic       sat_out;
  logic [1:0] sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_param u_ov (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .data_in_i     (data_in),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .data_out_o    (ov_out),
    .match_count_o (ov_cnt)
  );

  seq_detect_param #(
    .OVERLAP (0)
  ) u_no (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .data_in_i     (data_in),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .data_out_o    (no_out),
    .match_count_o (no_cnt)
  );

  seq_detect_param #(
    .INIT_PATTERN (4'b1111),
    .COUNT_W      (2)
  ) u_sat (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .data_in_i     (data_in),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .data_out_o    (sat_out),
    .match_count_o (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic tick(input logic e, input logic d, input logic ld);
    en       = e;
    data_in  = d;
    cfg_load = ld;
    @(posedge clk);
    #1;
    en       = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset(input logic ld);
    reset    = 1'b1;
    en       = 1'b0;
    cfg_load = ld;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    logic [9:0] exp_ov;
    logic [9:0] exp_no;
    logic [6:0] gap_bits;
    logic [7:0] sat_pulse;
    logic [3:0] pat4;
    logic [3:0] exp4;
    int         sat_exp;

    reset       = 1'b0;
    en          = 1'b0;
    data_in     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 4'b0000;
    @(posedge clk);
    #1;

    // Reset state
    do_reset(1'b0);
    check("rst_ov_out", 32'(ov_out), 0);
    check("rst_ov_cnt", 32'(ov_cnt), 0);
    check("rst_no_cnt", 32'(no_cnt), 0);
    check("rst_sat_cnt", 32'(sat_cnt), 0);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1 then 0,1,1
    bits   = 10'b1011011011;
    exp_ov = 10'b0001001001;
    exp_no = 10'b0001000001;
    for (int i = 9; i >= 0; i--) begin
      tick(1'b1, bits[i], 1'b0);
      check($sformatf("ov_pulse%0d", 10 - i), 32'(ov_out), 32'(exp_ov[i]));
      check($sformatf("no_pulse%0d", 10 - i), 32'(no_out), 32'(exp_no[i]));
      if (i == 3) begin
        check("ov_cnt_after7", 32'(ov_cnt), 2);
        check("no_cnt_after7", 32'(no_cnt), 1);
      end
    end
    check("ov_cnt_after10", 32'(ov_cnt), 3);
    check("no_cnt_after10", 32'(no_cnt), 2);
    check("sat_no_match", 32'(sat_cnt), 0);

    // en gaps: 1,0 then 5 idle cycles with toggling data, then 1,1
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    gap_bits = 7'b1010111;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, gap_bits[i], 1'b0);
      check($sformatf("gap_idle%0d", i), 32'(ov_out), 0);
    end
    tick(1'b1, 1'b1, 1'b0);
    check("gap_pre", 32'(ov_out), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("gap_pulse", 32'(ov_out), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("gap_one_cycle", 32'(ov_out), 0);
    check("gap_cnt", 32'(ov_cnt), 1);

    // Reset mid-sequence discards 1,0,1; next match needs four fresh bits
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("midrst_no_pulse", 32'(ov_out), 0);
    check("midrst_cnt", 32'(ov_cnt), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("midrst_b2", 32'(ov_out), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("midrst_b3", 32'(ov_out), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("midrst_pulse", 32'(ov_out), 1);

    // Runtime reload: load 0110 with en=1/data=1 (bit dropped), then 0,1,1,0
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    cfg_pattern = 4'b0110;
    tick(1'b1, 1'b1, 1'b1);
    check("load_out", 32'(ov_out), 0);
    check("load_cnt_hold", 32'(ov_cnt), 0);
    pat4 = 4'b0110;
    exp4 = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      tick(1'b1, pat4[i], 1'b0);
      check($sformatf("reload_b%0d", 4 - i), 32'(ov_out), 32'(exp4[i]));
    end
    check("reload_cnt", 32'(ov_cnt), 1);

    // Load right after a match clears the pulse but keeps the count
    tick(1'b1, 1'b1, 1'b1);
    check("load_clears_pulse", 32'(ov_out), 0);
    check("load_keeps_cnt", 32'(ov_cnt), 1);

    // Reset with simultaneous cfg_load keeps INIT_PATTERN (1011)
    cfg_pattern = 4'b0110;
    do_reset(1'b1);
    check("rst_ld_cnt", 32'(ov_cnt), 0);
    exp4 = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      tick(1'b1, pat4[i], 1'b0);
      check($sformatf("rst_ld_0110_b%0d", 4 - i), 32'(ov_out), 32'(exp4[i]));
    end
    tick(1'b1, 1'b1, 1'b0);
    check("rst_ld_1101", 32'(ov_out), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("rst_ld_1011", 32'(ov_out), 1);

    // Counter saturation: COUNT_W=2, pattern 1111, eight 1s
    do_reset(1'b0);
    sat_pulse = 8'b00011111;
    sat_exp   = 0;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, 1'b1, 1'b0);
      if (sat_pulse[i] && sat_exp < 3) sat_exp++;
      check($sformatf("sat_pulse%0d", 8 - i), 32'(sat_out), 32'(sat_pulse[i]));
      check($sformatf("sat_cnt%0d", 8 - i), 32'(sat_cnt), 32'(sat_exp));
    end
    tick(1'b0, 1'b1, 1'b0);
    check("sat_idle_out", 32'(sat_out), 0);
    check("sat_hold", 32'(sat_cnt), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
